// File: rtl/switch_debounce_capture.sv
// switch_debounce_capture: synchronize, debounce and report changes on board switches
//   CLOCK_50_I/RESETN_I : clock, asynchronous active-low reset
//   SWITCH_I            : raw bouncing switch levels
//   SW_DEB_O            : debounced levels
//   SW_RISE_O/SW_FALL_O : one-cycle pulses on accepted 0->1 / 1->0
//   EVENT_VALID_O/EVENT_IDX_O/EVENT_DIR_O/EVENT_ACK_I : valid/ack change-event record
//   OVERFLOW_O          : sticky, an event was lost while one was pending
//   EVENT_COUNT_O       : accepted event count when SWITCH_EVENT_COUNT_EN is defined, else 0
module switch_debounce_capture #(
    parameter int NUM_SW         = 18,
    parameter int TICK_CYCLES    = 500000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic              CLOCK_50_I,
    input  logic              RESETN_I,
    input  logic [NUM_SW-1:0] SWITCH_I,
    output logic [NUM_SW-1:0] SW_DEB_O,
    output logic [NUM_SW-1:0] SW_RISE_O,
    output logic [NUM_SW-1:0] SW_FALL_O,
    output logic              EVENT_VALID_O,
    output logic [4:0]        EVENT_IDX_O,
    output logic              EVENT_DIR_O,
    input  logic              EVENT_ACK_I,
    output logic              OVERFLOW_O,
    output logic [15:0]       EVENT_COUNT_O
);
    localparam int CW = $clog2(TICK_CYCLES);

    typedef enum logic {IDLE, PENDING} state_t;

    logic [NUM_SW-1:0]                     sync1_q, sync2_q;
    logic [CW-1:0]                         tick_cnt_q, tick_cnt_d;
    logic [NUM_SW-1:0][STABLE_SAMPLES-1:0] hist_q, hist_d;
    logic [NUM_SW-1:0]                     deb_q, deb_d, rise_q, rise_d, fall_q, fall_d, chg;
    state_t                                state_q, state_d;
    logic                                  valid_q, valid_d, dir_q, dir_d, ovf_q, ovf_d;
    logic [4:0]                            idx_q, idx_d, hi_idx;
    logic                                  hi_dir, tick, load;

    // Accepts are judged on the history as it will stand after this tick, so
    // the new level and its pulse appear the cycle after the tick.
    always_comb begin
        tick       = tick_cnt_q == CW'(TICK_CYCLES - 1);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        hist_d     = hist_q;
        rise_d     = '0;
        fall_d     = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (tick)
                hist_d[i] = {hist_q[i][STABLE_SAMPLES-2:0], sync2_q[i]};
            rise_d[i] = tick & (&hist_d[i]) & ~deb_q[i];
            fall_d[i] = tick & ~(|hist_d[i]) & deb_q[i];
        end
        deb_d = (deb_q | rise_d) & ~fall_d;
        chg   = rise_d | fall_d;
        // Highest-numbered changed switch wins the event record.
        hi_idx = '0;
        hi_dir = 1'b0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (chg[i]) begin
                hi_idx = 5'(i);
                hi_dir = rise_d[i];
            end
        end
        load    = (|chg) && (state_q == IDLE || EVENT_ACK_I);
        ovf_d   = ovf_q | ((|chg) && state_q == PENDING && !EVENT_ACK_I);
        state_d = load ? PENDING : (EVENT_ACK_I ? IDLE : state_q);
        valid_d = state_d == PENDING;
        idx_d   = load ? hi_idx : idx_q;
        dir_d   = load ? hi_dir : dir_q;
    end

    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            hist_q     <= '0;
            deb_q      <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            dir_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync1_q    <= SWITCH_I;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            hist_q     <= hist_d;
            deb_q      <= deb_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            state_q    <= state_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            ovf_q      <= ovf_d;
        end
    end

    assign SW_DEB_O      = deb_q;
    assign SW_RISE_O     = rise_q;
    assign SW_FALL_O     = fall_q;
    assign EVENT_VALID_O = valid_q;
    assign EVENT_IDX_O   = idx_q;
    assign EVENT_DIR_O   = dir_q;
    assign OVERFLOW_O    = ovf_q;

`ifdef SWITCH_EVENT_COUNT_EN
    logic [15:0] evt_cnt_q, evt_cnt_d;

    always_comb evt_cnt_d = evt_cnt_q + 16'(load);

    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I)
            evt_cnt_q <= '0;
        else
            evt_cnt_q <= evt_cnt_d;
    end

    assign EVENT_COUNT_O = evt_cnt_q;
`else
    assign EVENT_COUNT_O = 16'h0000;
`endif
endmodule

// File: tb/tb_switch_debounce_capture.sv
// tb_switch_debounce_capture: bench for switch_debounce_capture with a sample-list reference model
module tb_switch_debounce_capture;
    localparam int N = 18;
    localparam int T = 4;
    localparam int S = 3;
`ifdef SWITCH_EVENT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sw = '0;
    logic         ack = 1'b0;
    logic [N-1:0] deb, rise, fall;
    logic         valid, dir, ovf;
    logic [4:0]   idx;
    logic [15:0]  cnt;

    switch_debounce_capture #(.NUM_SW(N), .TICK_CYCLES(T), .STABLE_SAMPLES(S)) dut (
        .CLOCK_50_I(clk), .RESETN_I(rst_n), .SWITCH_I(sw),
        .SW_DEB_O(deb), .SW_RISE_O(rise), .SW_FALL_O(fall),
        .EVENT_VALID_O(valid), .EVENT_IDX_O(idx), .EVENT_DIR_O(dir),
        .EVENT_ACK_I(ack), .OVERFLOW_O(ovf), .EVENT_COUNT_O(cnt)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int mis = 0;

    // Reference model: edges since reset, the level seen through the
    // two-stage synchronizer, and the last S-1 tick samples.
    int           m_c;
    logic [N-1:0] m_s1, m_s2, m_deb, m_rise, m_fall;
    logic [N-1:0] smp[$];
    logic         m_valid, m_dir, m_ovf;
    logic [4:0]   m_idx;
    logic [15:0]  m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_c = 0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_rise = '0; m_fall = '0;
        m_valid = 1'b0; m_dir = 1'b0; m_ovf = 1'b0; m_idx = '0; m_cnt = '0;
        smp = {};
        for (int k = 0; k < S - 1; k++) smp.push_back('0);
    endtask

    // Accepts {rise, fall} that the coming clock edge will register.
    function automatic logic [2*N-1:0] acc_next();
        logic [N-1:0] a1, a0;
        if (m_c % T != T - 1) return '0;
        a1 = m_s2;
        a0 = m_s2;
        foreach (smp[k]) begin
            a1 &= smp[k];
            a0 |= smp[k];
        end
        return {a1 & ~m_deb, ~a0 & m_deb};
    endfunction

    task automatic model_step(input logic [N-1:0] s, input logic a);
        logic [N-1:0] r, f, chg;
        int hi;
        {r, f} = acc_next();
        if (m_c % T == T - 1) begin
            smp.push_back(m_s2);
            void'(smp.pop_front());
        end
        m_s2 = m_s1;
        m_s1 = s;
        chg = r | f;
        hi = 0;
        for (int i = N - 1; i >= 0; i--) if (chg[i]) begin hi = i; break; end
        if (chg != 0) begin
            if (!m_valid || a) begin
                m_valid = 1'b1; m_idx = 5'(hi); m_dir = r[hi]; m_cnt++;
            end else m_ovf = 1'b1;
        end else if (m_valid && a) m_valid = 1'b0;
        m_deb = (m_deb | r) & ~f;
        m_rise = r;
        m_fall = f;
        m_c++;
    endtask

    task automatic check_all();
        chk("deb", deb, m_deb);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("valid", valid, m_valid);
        chk("idx", idx, m_idx);
        chk("dir", dir, m_dir);
        chk("ovf", ovf, m_ovf);
        chk("count", cnt, CNT_EN ? m_cnt : 16'h0);
    endtask

    task automatic step();
        logic [N-1:0] s;
        logic a;
        s = sw;
        a = ack;
        @(posedge clk);
        if (rst_n) model_step(s, a); else model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] sw;
        logic         ack;
        logic [N-1:0] deb;
        logic         valid;
        logic [4:0]   idx;
        logic         dir;
        logic         ovf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int pulses, r3, f3, found, len;
        tbl[0] = '{18'h00000, 1'b0, 18'h00000, 1'b0, 5'd0,  1'b0, 1'b0};
        tbl[1] = '{18'h00001, 1'b0, 18'h00001, 1'b1, 5'd0,  1'b1, 1'b0};
        tbl[2] = '{18'h00001, 1'b1, 18'h00001, 1'b0, 5'd0,  1'b1, 1'b0};
        tbl[3] = '{18'h00007, 1'b0, 18'h00007, 1'b1, 5'd2,  1'b1, 1'b0};
        tbl[4] = '{18'h00000, 1'b0, 18'h00000, 1'b1, 5'd2,  1'b1, 1'b1};
        tbl[5] = '{18'h00000, 1'b1, 18'h00000, 1'b0, 5'd2,  1'b1, 1'b1};
        tbl[6] = '{18'h20000, 1'b0, 18'h20000, 1'b1, 5'd17, 1'b1, 1'b1};
        tbl[7] = '{18'h20000, 1'b1, 18'h20000, 1'b0, 5'd17, 1'b1, 1'b1};
        tbl[8] = '{18'h00000, 1'b0, 18'h00000, 1'b1, 5'd17, 1'b0, 1'b1};

        model_reset();
        @(negedge clk);
        do_reset();
        foreach (tbl[v]) begin
            sw = tbl[v].sw;
            ack = tbl[v].ack;
            step();
            ack = 1'b0;
            repeat (23) step();
            chk($sformatf("tbl%0d_deb", v), deb, tbl[v].deb);
            chk($sformatf("tbl%0d_valid", v), valid, tbl[v].valid);
            chk($sformatf("tbl%0d_ovf", v), ovf, tbl[v].ovf);
            if (tbl[v].valid) begin
                chk($sformatf("tbl%0d_idx", v), idx, tbl[v].idx);
                chk($sformatf("tbl%0d_dir", v), dir, tbl[v].dir);
            end
        end

        // Quiet after reset, then a clean rise on bit 0.
        sw = '0;
        do_reset();
        pulses = 0;
        repeat (100) begin
            step();
            if ((rise | fall) != 0) pulses++;
        end
        chk("quiet_pulses", pulses, 0);
        sw = 18'h00001;
        for (int k = 0; k < 14; k++) begin
            step();
            if (deb[0]) break;
        end
        chk("rise0_deb", deb, 18'h00001);
        chk("rise0_pulse", rise, 18'h00001);
        chk("rise0_valid", valid, 1);
        chk("rise0_idx", idx, 0);
        chk("rise0_dir", dir, 1);
        step();
        chk("rise0_pulse_end", rise, 0);

        // Bounce on bit 3 never holds 3 equal samples; only the final hold is accepted.
        ack = 1'b1;
        step();
        ack = 1'b0;
        r3 = 0;
        f3 = 0;
        for (int j = 0; j < 70; j++) begin
            sw[3] = (j >= 40) ? 1'b1 : ((j / 3) % 2 == 0);
            step();
            r3 += int'(rise[3]);
            f3 += int'(fall[3]);
        end
        chk("bounce_rises", r3, 1);
        chk("bounce_falls", f3, 0);

        // Ack on the very cycle bit 5 is accepted replaces the pending event.
        sw = '0;
        do_reset();
        sw = 18'h00001;
        for (int k = 0; k < 20 && !valid; k++) step();
        chk("ackacc_first_valid", valid, 1);
        sw = 18'h00021;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (acc_next()[N + 5]) begin found = 1; break; end
            step();
        end
        chk("ackacc_seen", found, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ackacc_valid", valid, 1);
        chk("ackacc_idx", idx, 5);
        chk("ackacc_dir", dir, 1);
        chk("ackacc_ovf", ovf, 0);

        // Three acknowledged toggles of bit 0.
        sw = '0;
        do_reset();
        repeat (3) begin
            sw[0] = ~sw[0];
            repeat (20) step();
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        chk("count3", cnt, CNT_EN ? 3 : 0);

        // Reset in the middle of debouncing bit 1, then rise seen after release.
        sw = 18'h00003;
        repeat (6) step();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_deb", deb, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_idx", idx, 0);
        chk("rst_count", cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (deb == 18'h00003 && found == 0) found = k;
        end
        chk("rst_rise_latency", found, 12);

        // Random traffic checked every cycle against the model.
        sw = '0;
        do_reset();
        repeat (250) begin
            sw = sw ^ (18'($urandom) & 18'($urandom));
            len = $urandom_range(1, 24);
            repeat (len) begin
                ack = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
